// File: rtl/dca_matrix_lsu_row_sequencer_pkg.sv
// dca_matrix_lsu_row_sequencer_pkg: shared widths, FSM encoding and row-size helper.
// Revision 1.0
`default_nettype none

package dca_matrix_lsu_row_sequencer_pkg;

   // DCA matrix info field widths
   localparam int DCA_MATRIX_BW_ADDR       = 32;
   localparam int DCA_MATRIX_BW_STRIDE_LS3 = 16;
   localparam int DCA_MATRIX_BW_NUM_ROW_M1 = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam logic [2:0] LSA_P3_1BIT  = 3'd0;
   localparam logic [2:0] LSA_P3_2BIT  = 3'd1;
   localparam logic [2:0] LSA_P3_4BIT  = 3'd2;
   localparam logic [2:0] LSA_P3_8BIT  = 3'd3;
   localparam logic [2:0] LSA_P3_16BIT = 3'd4;
   localparam logic [2:0] LSA_P3_32BIT = 3'd5;

   // Codes above 32-bit clamp to 32-bit; sub-byte rows still occupy one byte.
   function automatic logic [7:0] row_num_byte(input logic [2:0] lsa_p3,
                                               input int unsigned num_col);
      logic [2:0]  shamt;
      int unsigned nbyte;
      shamt = (lsa_p3 > LSA_P3_32BIT) ? LSA_P3_32BIT : lsa_p3;
      nbyte = (num_col << shamt) >> 3;
      return (nbyte == 0) ? 8'd1 : nbyte[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/dca_matrix_lsu_row_sequencer_if.sv
// dca_matrix_lsu_row_sequencer_if: descriptor, row-request and status bundle.
// Optional macro DCA_LSU_ROW_SEQ_PERF_EN adds perf_stall_cycle / perf_total_cycle. Revision 1.0
`default_nettype none

interface dca_matrix_lsu_row_sequencer_if
   import dca_matrix_lsu_row_sequencer_pkg::*;
#(
   parameter int BW_ADDR       = DCA_MATRIX_BW_ADDR,
   parameter int BW_STRIDE_LS3 = DCA_MATRIX_BW_STRIDE_LS3,
   parameter int BW_NUM_ROW_M1 = DCA_MATRIX_BW_NUM_ROW_M1
);
   logic                     inst_valid;
   logic                     inst_ready;
   logic [BW_ADDR-1:0]       inst_addr;
   logic [BW_STRIDE_LS3-1:0] inst_stride_ls3;
   logic [BW_NUM_ROW_M1-1:0] inst_num_row_m1;
   logic [2:0]               inst_lsa_p3;

   logic                     req_valid;
   logic                     req_ready;
   logic [BW_ADDR-1:0]       req_addr;
   logic [7:0]               req_num_byte;
   logic [BW_NUM_ROW_M1-1:0] req_row_idx;
   logic                     req_last;

   logic                     rsp_done;
   logic                     busy;
   logic                     done;
   logic                     error;
`ifdef DCA_LSU_ROW_SEQ_PERF_EN
   logic [31:0]              perf_stall_cycle;
   logic [31:0]              perf_total_cycle;
`endif

   modport master (
      input  inst_valid, inst_addr, inst_stride_ls3, inst_num_row_m1, inst_lsa_p3,
      input  req_ready, rsp_done,
      output inst_ready, req_valid, req_addr, req_num_byte, req_row_idx, req_last,
      output busy, done, error
`ifdef DCA_LSU_ROW_SEQ_PERF_EN
      , output perf_stall_cycle, perf_total_cycle
`endif
   );

   modport slave (
      output inst_valid, inst_addr, inst_stride_ls3, inst_num_row_m1, inst_lsa_p3,
      output req_ready, rsp_done,
      input  inst_ready, req_valid, req_addr, req_num_byte, req_row_idx, req_last,
      input  busy, done, error
`ifdef DCA_LSU_ROW_SEQ_PERF_EN
      , input perf_stall_cycle, perf_total_cycle
`endif
   );

endinterface

`default_nettype wire

// File: rtl/dca_matrix_lsu_row_sequencer_outstanding.sv
// dca_lsu_outstanding_counter: in-flight row request tracker with full flag and sticky underflow error.
// Revision 1.0
`default_nettype none

module dca_lsu_outstanding_counter #(
   parameter  int MAX_OUTSTANDING = 4,
   localparam int BW_CNT          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  wire logic clk,
   input  wire logic rstnn,
   input  wire logic inc_i,
   input  wire logic dec_i,
   output logic      full_o,
   output logic      empty_o,
   output logic      error_o
);

   logic [BW_CNT-1:0] count_q, count_d;
   logic              error_q, error_d;
   logic              w_inc;

   assign full_o  = (count_q == BW_CNT'(MAX_OUTSTANDING));
   assign empty_o = (count_q == '0);
   assign error_o = error_q;
   assign w_inc   = inc_i & ~full_o;

   // Simultaneous increment and decrement cancel out.
   always_comb begin
      count_d = count_q;
      error_d = error_q;
      case ({w_inc, dec_i})
         2'b10: count_d = count_q + BW_CNT'(1);
         2'b01: begin
            if (empty_o) error_d = 1'b1;
            else         count_d = count_q - BW_CNT'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         count_q <= count_d;
         error_q <= error_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dca_matrix_lsu_row_sequencer.sv
// dca_matrix_lsu_row_sequencer: walks a matrix descriptor into per-row read requests.
// Optional macro DCA_LSU_ROW_SEQ_PERF_EN enables stall/total cycle counters. Revision 1.0
`default_nettype none

module dca_matrix_lsu_row_sequencer
   import dca_matrix_lsu_row_sequencer_pkg::*;
#(
   parameter int unsigned MATRIX_NUM_COL  = 4,
   parameter int          BW_ADDR         = DCA_MATRIX_BW_ADDR,
   parameter int          BW_STRIDE_LS3   = DCA_MATRIX_BW_STRIDE_LS3,
   parameter int          BW_NUM_ROW_M1   = DCA_MATRIX_BW_NUM_ROW_M1,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  wire logic                      clk,
   input  wire logic                      rstnn,
   dca_matrix_lsu_row_sequencer_if.master bus
);

   seq_state_e               state_q, state_d;
   logic                     armed_q;
   logic [BW_ADDR-1:0]       addr_q, addr_d;
   logic [BW_STRIDE_LS3-1:0] stride_q, stride_d;
   logic [BW_NUM_ROW_M1-1:0] num_row_m1_q, num_row_m1_d;
   logic [BW_NUM_ROW_M1-1:0] row_idx_q, row_idx_d;
   logic [7:0]               num_byte_q, num_byte_d;

   logic w_inst_ready, w_req_valid, w_req_last, w_busy, w_done;
   logic w_accept, w_req_hs, w_full, w_empty, w_error;
   logic [BW_ADDR-1:0] w_stride_byte;

   assign w_accept      = bus.inst_valid & w_inst_ready;
   assign w_req_hs      = w_req_valid & bus.req_ready;
   assign w_stride_byte = BW_ADDR'({stride_q, 3'b000});

   dca_lsu_outstanding_counter #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_outstanding (
      .clk     (clk),
      .rstnn   (rstnn),
      .inc_i   (w_req_hs),
      .dec_i   (bus.rsp_done),
      .full_o  (w_full),
      .empty_o (w_empty),
      .error_o (w_error)
   );

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (w_accept)              state_d = ST_ISSUE;
         ST_ISSUE: if (w_req_hs & w_req_last) state_d = ST_DRAIN;
         ST_DRAIN: if (w_empty)               state_d = ST_DONE;
         ST_DONE:                             state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   // armed_q keeps inst_ready low while reset is applied and for the release cycle.
   always_comb begin
      w_inst_ready = 1'b0;
      w_req_valid  = 1'b0;
      w_req_last   = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (state_q)
         ST_IDLE:  w_inst_ready = armed_q;
         ST_ISSUE: begin
            w_busy      = 1'b1;
            w_req_valid = ~w_full;
            w_req_last  = (row_idx_q == num_row_m1_q);
         end
         ST_DRAIN: w_busy = 1'b1;
         ST_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      addr_d       = addr_q;
      stride_d     = stride_q;
      num_row_m1_d = num_row_m1_q;
      row_idx_d    = row_idx_q;
      num_byte_d   = num_byte_q;
      if (w_accept) begin
         addr_d       = bus.inst_addr;
         stride_d     = bus.inst_stride_ls3;
         num_row_m1_d = bus.inst_num_row_m1;
         row_idx_d    = '0;
         num_byte_d   = row_num_byte(bus.inst_lsa_p3, MATRIX_NUM_COL);
      end else if (w_req_hs) begin
         addr_d    = addr_q + w_stride_byte;
         row_idx_d = row_idx_q + BW_NUM_ROW_M1'(1);
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         armed_q      <= 1'b0;
         addr_q       <= '0;
         stride_q     <= '0;
         num_row_m1_q <= '0;
         row_idx_q    <= '0;
         num_byte_q   <= '0;
      end else begin
         armed_q      <= 1'b1;
         addr_q       <= addr_d;
         stride_q     <= stride_d;
         num_row_m1_q <= num_row_m1_d;
         row_idx_q    <= row_idx_d;
         num_byte_q   <= num_byte_d;
      end
   end

   assign bus.inst_ready   = w_inst_ready;
   assign bus.req_valid    = w_req_valid;
   assign bus.req_addr     = addr_q;
   assign bus.req_num_byte = num_byte_q;
   assign bus.req_row_idx  = row_idx_q;
   assign bus.req_last     = w_req_last;
   assign bus.busy         = w_busy;
   assign bus.done         = w_done;
   assign bus.error        = w_error;

`ifdef DCA_LSU_ROW_SEQ_PERF_EN
   logic [31:0] perf_stall_q, perf_total_q;
   logic        w_stall;

   // Stall: held off by the in-flight limit, or offered but not taken.
   assign w_stall = (state_q == ST_ISSUE) & (w_full | ~bus.req_ready);

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         perf_stall_q <= '0;
         perf_total_q <= '0;
      end else if (w_accept) begin
         perf_stall_q <= '0;
         perf_total_q <= '0;
      end else begin
         if (w_stall & ~&perf_stall_q) perf_stall_q <= perf_stall_q + 32'd1;
         if (w_busy  & ~&perf_total_q) perf_total_q <= perf_total_q + 32'd1;
      end
   end

   assign bus.perf_stall_cycle = perf_stall_q;
   assign bus.perf_total_cycle = perf_total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dca_matrix_lsu_row_sequencer.sv
// tb_dca_matrix_lsu_row_sequencer: table, directed and randomized checks of the row sequencer.
// Revision 1.0
`default_nettype none

module tb_dca_matrix_lsu_row_sequencer;

   localparam int MAX_OUT = 4;
   localparam int NUM_COL = 4;

   logic clk   = 1'b0;
   logic rstnn = 1'b1;
   always #5 clk = ~clk;

   dca_matrix_lsu_row_sequencer_if bus ();

   dca_matrix_lsu_row_sequencer dut (
      .clk   (clk),
      .rstnn (rstnn),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] stride;
      logic [3:0]  nrm1;
      logic [2:0]  lsa;
      int          ready_pct;
      int          rsp_pct;
      logic [7:0]  exp_nb;
      logic [31:0] exp_last_addr;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.inst_valid      = 1'b0;
      bus.inst_addr       = '0;
      bus.inst_stride_ls3 = '0;
      bus.inst_num_row_m1 = '0;
      bus.inst_lsa_p3     = '0;
      bus.req_ready       = 1'b0;
      bus.rsp_done        = 1'b0;
   endtask

   // Asserted between edges: outputs must clear without waiting for a clock.
   task automatic do_reset();
      idle_inputs();
      rstnn = 1'b0;
      #2;
      check("rst_ctrl", {bus.inst_ready, bus.req_valid, bus.req_last, bus.busy, bus.done, bus.error}, 0);
      check("rst_addr", bus.req_addr, 0);
      check("rst_nbyte_idx", {bus.req_num_byte, bus.req_row_idx}, 0);
      @(posedge clk);
      #2;
      rstnn = 1'b1;
      tick();
      check("inst_ready_after_rst", {bus.inst_ready, bus.busy}, 2'b10);
   endtask

   task automatic accept(input logic [31:0] a, input logic [15:0] s, input logic [3:0] n, input logic [2:0] l);
      int k = 0;
      while (bus.inst_ready !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("inst_ready_wait", bus.inst_ready, 1);
      bus.inst_valid      = 1'b1;
      bus.inst_addr       = a;
      bus.inst_stride_ls3 = s;
      bus.inst_num_row_m1 = n;
      bus.inst_lsa_p3     = l;
      tick();
      bus.inst_valid = 1'b0;
      check("first_req_latency", {bus.req_valid, bus.busy}, 2'b11);
   endtask

   task automatic count_hs(input int ncyc, output int cnt);
      cnt = 0;
      bus.req_ready = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         if (bus.req_valid === 1'b1) cnt++;
         tick();
      end
      bus.req_ready = 1'b0;
   endtask

   // Reference model: rows are addr + i*stride*8 (mod 2^32); at most MAX_OUT unanswered;
   // done pulses the cycle after everything is issued and answered.
   task automatic run_desc(input vec_t v, output logic [7:0] first_nb, output logic [31:0] last_addr);
      int          issued = 0;
      int          outst  = 0;
      int          nrows;
      int          sh;
      int          bits;
      bit          drained_prev = 1'b0;
      bit          finished     = 1'b0;
      logic [7:0]  exp_nb;
      logic [31:0] exp_addr;
      bit          rdy, rsp, hs;

      nrows  = int'(v.nrm1) + 1;
      sh     = (v.lsa > 3'd5) ? 5 : int'(v.lsa);
      bits   = NUM_COL * (2 ** sh);
      exp_nb = (bits / 8 == 0) ? 8'd1 : 8'(bits / 8);
      first_nb  = '0;
      last_addr = '0;
      accept(v.addr, v.stride, v.nrm1, v.lsa);

      for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
         check("req_valid", bus.req_valid, (issued < nrows && outst < MAX_OUT) ? 1 : 0);
         check("done", bus.done, drained_prev ? 1 : 0);
         if (drained_prev) begin
            finished = 1'b1;
            check("inst_ready_in_done", bus.inst_ready, 0);
            tick();
            check("inst_ready_post_done", {bus.inst_ready, bus.busy}, 2'b10);
         end else begin
            rdy = ($urandom_range(0, 99) < v.ready_pct);
            rsp = (outst > 0) && ($urandom_range(0, 99) < v.rsp_pct);
            hs  = (bus.req_valid === 1'b1) && rdy;
            if (hs) begin
               exp_addr = v.addr + 32'(issued) * (32'(v.stride) << 3);
               check("req_addr", bus.req_addr, exp_addr);
               check("req_num_byte", bus.req_num_byte, exp_nb);
               check("req_row_idx_last", {bus.req_row_idx, bus.req_last},
                     {4'(issued), (issued == nrows - 1) ? 1'b1 : 1'b0});
               if (issued == 0) first_nb = bus.req_num_byte;
               last_addr = bus.req_addr;
            end
            drained_prev  = (issued == nrows) && (outst == 0);
            bus.req_ready = rdy;
            bus.rsp_done  = rsp;
            tick();
            bus.rsp_done  = 1'b0;
            bus.req_ready = 1'b0;
            issued += hs ? 1 : 0;
            outst  += (hs ? 1 : 0) - (rsp ? 1 : 0);
         end
      end
      check("desc_completed", finished, 1);
      check("no_error", bus.error, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          c;
      logic [7:0]  nb;
      logic [31:0] la;
      logic [31:0] bp_addr;
      vec_t        rv;

      vecs[0] = '{32'h0000_1000, 16'd2,      4'd3,  3'd3, 100, 50, 8'd4,  32'h0000_1030};
      vecs[1] = '{32'h0000_2000, 16'd1,      4'd0,  3'd0, 100, 60, 8'd1,  32'h0000_2000};
      vecs[2] = '{32'h0000_0000, 16'h0010,   4'd2,  3'd7, 70,  40, 8'd16, 32'h0000_0100};
      vecs[3] = '{32'hFFFF_FFF0, 16'd4,      4'd1,  3'd5, 100, 50, 8'd16, 32'h0000_0010};
      vecs[4] = '{32'h0000_0040, 16'd0,      4'd5,  3'd1, 50,  30, 8'd1,  32'h0000_0040};
      vecs[5] = '{32'h0000_0100, 16'd3,      4'd7,  3'd4, 80,  20, 8'd8,  32'h0000_01A8};
      vecs[6] = '{32'h0000_8000, 16'hFFFF,   4'd1,  3'd2, 60,  50, 8'd2,  32'h0008_7FF8};

      idle_inputs();
      #2;
      do_reset();

      for (int i = 0; i < 7; i++) begin
         run_desc(vecs[i], nb, la);
         check("tbl_num_byte", nb, vecs[i].exp_nb);
         check("tbl_last_addr", la, vecs[i].exp_last_addr);
      end

      // In-flight limit: four issue, then one more per response.
      do_reset();
      accept(32'h0, 16'd1, 4'd7, 3'd3);
      count_hs(8, c);
      check("limit_count", c, MAX_OUT);
      check("limit_valid_low", bus.req_valid, 0);
      bus.rsp_done = 1'b1;
      tick();
      bus.rsp_done = 1'b0;
      check("limit_valid_after_rsp", {bus.req_valid, bus.req_row_idx}, {1'b1, 4'd4});
      count_hs(6, c);
      check("limit_one_more", c, 1);

      // Backpressure holds the payload and the in-flight count.
      do_reset();
      accept(32'h500, 16'd2, 4'd7, 3'd3);
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      bp_addr = 32'h510;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_addr", bus.req_addr, bp_addr);
         check("bp_ctrl", {bus.req_valid, bus.req_last, bus.req_row_idx}, {1'b1, 1'b0, 4'd1});
      end
      count_hs(8, c);
      check("bp_remaining_slots", c, 3);

      // Handshake together with a response leaves the count at two.
      do_reset();
      accept(32'h0, 16'd1, 4'd7, 3'd3);
      count_hs(2, c);
      check("sim_pre_count", c, 2);
      check("sim_valid", bus.req_valid, 1);
      bus.req_ready = 1'b1;
      bus.rsp_done  = 1'b1;
      tick();
      bus.rsp_done  = 1'b0;
      count_hs(6, c);
      check("sim_remaining_slots", c, 2);

      // Randomized descriptors against the model.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         rv.addr          = $urandom;
         rv.stride        = 16'($urandom);
         rv.nrm1          = 4'($urandom);
         rv.lsa           = 3'($urandom);
         rv.ready_pct     = $urandom_range(30, 100);
         rv.rsp_pct       = $urandom_range(20, 80);
         rv.exp_nb        = '0;
         rv.exp_last_addr = '0;
         run_desc(rv, nb, la);
      end

      // Underflow error is sticky; reset mid-issue clears everything.
      do_reset();
      bus.rsp_done = 1'b1;
      tick();
      bus.rsp_done = 1'b0;
      check("err_set", bus.error, 1);
      repeat (3) tick();
      check("err_sticky", bus.error, 1);
      accept(32'h3000, 16'd1, 4'd7, 3'd3);
      bus.req_ready = 1'b1;
      tick();
      tick();
      bus.req_ready = 1'b0;
      check("err_row2", {bus.req_row_idx, bus.busy, bus.error}, {4'd2, 1'b1, 1'b1});
      do_reset();
      check("err_cleared", bus.error, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dca_matrix_lsu_row_sequencer.md
Name: dca_matrix_lsu_row_sequencer

Overview:
- Sequences one matrix LSU load instruction into per-row read transactions for the DCA matrix LSU.
- Takes a matrix descriptor: base address, stride, row count and element width code. Walks the rows and issues one row request per handshake.
- Limits in-flight requests to a fixed number and retires rows as the response formatter consumes them.
- Sits between the LSU instruction decoder and the AXI read issue path. Signals completion back to the instruction queue.

Parameters:
- MATRIX_NUM_COL, 4, elements per matrix row.
- BW_ADDR, 32, address width.
- BW_STRIDE_LS3, 16, width of stride field; byte stride = stride_ls3 << 3.
- BW_NUM_ROW_M1, 4, width of row-count-minus-1 field.
- MAX_OUTSTANDING, 4, maximum in-flight row requests (>=1).

Ports:
- clk  input  1  clock
- rstnn  input  1  asynchronous active-low reset
- inst_valid  input  1  descriptor valid
- inst_ready  output  1  descriptor accepted
- inst_addr  input  BW_ADDR  matrix base byte address
- inst_stride_ls3  input  BW_STRIDE_LS3  row stride in 8-byte units
- inst_num_row_m1  input  BW_NUM_ROW_M1  rows minus 1
- inst_lsa_p3  input  3  element width code; 0..5 = 1,2,4,8,16,32 bits; 6,7 treated as 5
- req_valid  output  1  row request valid
- req_ready  input  1  issue path accepts request
- req_addr  output  BW_ADDR  row byte address
- req_num_byte  output  8  row length in bytes
- req_row_idx  output  BW_NUM_ROW_M1  row index
- req_last  output  1  final row of matrix
- rsp_done  input  1  one row fully consumed by response formatter (pulse)
- busy  output  1  descriptor in progress
- done  output  1  one-cycle completion pulse
- error  output  1  sticky: rsp_done seen with zero outstanding

Behaviour:
- Reset values: inst_ready=0, req_valid=0, req_addr=0, req_num_byte=0, req_row_idx=0, req_last=0, busy=0, done=0, error=0. Internal counters are 0 and the FSM is in IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - inst_ready=1.
  - On inst_valid & inst_ready, latch the descriptor and set cur_addr=inst_addr, row_idx=0.
  - Compute req_num_byte = max(1, (MATRIX_NUM_COL << min(lsa_p3,5)) >> 3).
  - Next state: ISSUE.
- ISSUE:
  - req_valid=1 when outstanding < MAX_OUTSTANDING, else 0.
  - The request payload is driven from registers. Once req_valid=1, the payload holds stable until handshake.
  - On req_valid & req_ready: cur_addr += stride_ls3<<3, wrapping modulo 2^BW_ADDR; row_idx++.
  - req_last = (row_idx == num_row_m1).
  - Handshake with req_last moves the FSM to DRAIN.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. inst_ready is 0 in this state, so back-to-back descriptors incur one cycle of bubble.
- busy=1 in ISSUE, DRAIN and DONE.
- Outstanding counter:
  - +1 on request handshake, -1 on rsp_done.
  - Both in the same cycle: the counter is unchanged.
  - rsp_done at outstanding==0: the counter stays 0 and error is set. error clears only on reset.
- Full: at outstanding==MAX_OUTSTANDING, req_valid deasserts the next cycle. The row_idx and addr registers hold.
- Latency: first req_valid appears 1 cycle after descriptor acceptance. With req_ready held high and no outstanding stall, one row is issued per cycle.
- num_row_m1=0: the single request carries req_last=1.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). In-flight responses are not tracked afterwards.
- rsp_done in IDLE is an error case (outstanding==0).

Optional Feature:
- Macro: DCA_LSU_ROW_SEQ_PERF_EN.
- When defined, two additional outputs are present:
  - perf_stall_cycle, 32 bits: counts ISSUE cycles with req_valid=0 due to outstanding limit, or with req_valid & !req_ready.
  - perf_total_cycle, 32 bits: counts busy cycles.
- Both counters clear on descriptor acceptance and saturate at all-ones.
- When not defined, the ports and counters are absent, with no other change.

Decomposition:
- Shared package/include:
  - FSM state encodings.
  - Element width code constants (LSA_P3_1BIT..LSA_P3_32BIT).
  - Row-byte function.
  - Reuse the existing DCA matrix info width defines for the address, stride and row fields.
- Natural sub-module: dca_lsu_outstanding_counter. It implements the up/down counter, full flag and underflow error for MAX_OUTSTANDING.

Test Plan:
- Basic walk:
  - Stimulus: addr=0x1000, stride_ls3=2, num_row_m1=3, lsa_p3=3, MATRIX_NUM_COL=4, req_ready=1, rsp_done 2 cycles after each request.
  - Required: req_addr 0x1000, 0x1010, 0x1020, 0x1030; req_num_byte=4; req_last only on row 3; done pulse once after the 4th rsp_done.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=4, num_row_m1=7, req_ready=1, rsp_done withheld.
  - Required: exactly 4 requests; req_valid=0 until the first rsp_done, then exactly one more request issues.
- Backpressure:
  - Stimulus: req_ready=0 for 5 cycles while req_valid=1.
  - Required: req_addr, req_row_idx and req_last stable; no counter change.
- Simultaneous and wrap:
  - Stimulus: handshake and rsp_done in the same cycle with outstanding=2; separately addr=0xFFFFFFF0 with stride_ls3=4.
  - Required: outstanding stays 2; second req_addr=0x00000010.
- Error and reset:
  - Stimulus: rsp_done in IDLE; separately, rstnn low during ISSUE at row 2.
  - Required: error=1, and it persists; after reset, all outputs are 0, state is IDLE, and inst_ready=1 on the first clock after release.
- Width codes:
  - Stimulus: lsa_p3=0 with MATRIX_NUM_COL=4, then lsa_p3=7.
  - Required: req_num_byte=1 and 16 respectively.
